// File: rtl/idelay_fine_pipe_multi.sv
// Multi-lane fine-delay controller: per-lane/broadcast pre-load, then a shared immediate or
// one-fine-unit-per-step apply sequence driving IDELAYE2_FINEDELAY-style lanes.

// Behavioural stand-in for one IDELAYE2_FINEDELAY lane (VAR_LOAD_PIPE, FINEDELAY=ADD_DLY).
module idelay_fine_lane #(
   parameter logic [7:0] INIT = 8'h00
) (
   input  logic       clk,
   input  logic       regrst,
   input  logic       ldpipeen,
   input  logic       ld,
   input  logic [4:0] cntvaluein,
   input  logic [2:0] ifdly,
   input  logic       idatain,
   output logic       dataout,
   output logic [7:0] dlyout
);
   logic [4:0] pipe_q;
   logic [4:0] cnt_q;
   logic [2:0] fine_q;

   // pipeline register, tap counter and fine-delay register
   always_ff @(posedge clk) begin
      if (regrst) begin
         pipe_q <= INIT[7:3];
         cnt_q  <= INIT[7:3];
         fine_q <= INIT[2:0];
      end else begin
         if (ldpipeen) begin
            pipe_q <= cntvaluein;
         end
         if (ld) begin
            cnt_q  <= pipe_q;
            fine_q <= ifdly;
         end
      end
   end

   // the analogue tap delay itself is not modelled
   assign dataout = idatain;
   assign dlyout  = {cnt_q, fine_q};
endmodule

module idelay_fine_pipe_multi #(
   parameter int         NUM_CHN               = 8,
   parameter int         CHN_BITS              = 3,
   parameter             IODELAY_GRP           = "IODELAY_MEMORY",
   parameter logic [7:0] DELAY_VALUE           = 8'h00,
   parameter real        REFCLK_FREQUENCY      = 200.0,
   parameter             HIGH_PERFORMANCE_MODE = "FALSE",
   parameter int         SETTLE_CYCLES         = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ld,
   input  logic [CHN_BITS-1:0] sel,
   input  logic                bcast,
   input  logic [7:0]          delay,
   input  logic                set,
   input  logic                step_mode,
   output logic                busy,
   output logic                fine_err,
   input  logic [NUM_CHN-1:0]  data_in,
   output logic [NUM_CHN-1:0]  data_out
);
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PIPE  = 2'd1,
      S_APPLY = 2'd2,
      S_WAIT  = 2'd3
   } state_t;

   localparam logic [2:0] FINE_MAX    = 3'd4;
   localparam logic [7:0] RST_DLY     = {DELAY_VALUE[7:3],
                                         (DELAY_VALUE[2:0] > FINE_MAX) ? FINE_MAX : DELAY_VALUE[2:0]};
   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

   if (NUM_CHN < 1 || NUM_CHN > 32 || (2 ** CHN_BITS) < NUM_CHN ||
       SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255 || DELAY_VALUE[2:0] > FINE_MAX ||
       REFCLK_FREQUENCY < 190.0 || REFCLK_FREQUENCY > 310.0 || IODELAY_GRP == "" ||
       (HIGH_PERFORMANCE_MODE != "TRUE" && HIGH_PERFORMANCE_MODE != "FALSE")) begin : g_bad_cfg
      $error("idelay_fine_pipe_multi: invalid parameter set");
   end

   function automatic logic [7:0] clamp_fine(input logic [7:0] d);
      return {d[7:3], (d[2:0] > FINE_MAX) ? FINE_MAX : d[2:0]};
   endfunction

   // {coarse,fine} with fine in 0..4 orders correctly as a plain 8-bit number
   function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
      logic [4:0] c;
      logic [2:0] f;
      c = cur[7:3];
      f = cur[2:0];
      if (cur < tgt) begin
         if (f == FINE_MAX) begin
            c = c + 5'd1;
            f = 3'd0;
         end else begin
            f = f + 3'd1;
         end
      end else if (cur > tgt) begin
         if (f == 3'd0) begin
            c = c - 5'd1;
            f = FINE_MAX;
         end else begin
            f = f - 3'd1;
         end
      end else begin
         c = cur[7:3];
      end
      return {c, f};
   endfunction

   state_t     state_q, state_d;
   logic [7:0] pre_q [NUM_CHN];
   logic [7:0] pre_d [NUM_CHN];
   logic [7:0] tgt_q [NUM_CHN];
   logic [7:0] tgt_d [NUM_CHN];
   logic [7:0] nxt_q [NUM_CHN];
   logic [7:0] nxt_d [NUM_CHN];
   logic [7:0] nxt_s [NUM_CHN];
   logic [7:0] cur_s [NUM_CHN];
   logic       all_eq_s;
   logic       mode_q, mode_d;
   logic [7:0] wait_q, wait_d;
   logic       ldpipeen_q, ldpipeen_d;
   logic       ld_q, ld_d;
   logic       busy_q, busy_d;
   logic       fine_err_q, fine_err_d;

   // candidate next delay per lane, and whether the last computed step reaches every target
   always_comb begin
      all_eq_s = 1'b1;
      for (int i = 0; i < NUM_CHN; i++) begin
         nxt_s[i] = mode_q ? step_toward(cur_s[i], tgt_q[i]) : tgt_q[i];
         all_eq_s = all_eq_s & (nxt_q[i] == tgt_q[i]);
      end
   end

   // pre-load handling and apply sequencer next state
   always_comb begin
      state_d    = state_q;
      tgt_d      = tgt_q;
      nxt_d      = nxt_q;
      mode_d     = mode_q;
      wait_d     = wait_q;
      fine_err_d = fine_err_q | (ld & (delay[2:0] > FINE_MAX));
      for (int i = 0; i < NUM_CHN; i++) begin
         if (ld && (bcast || (int'(sel) == i))) begin
            pre_d[i] = clamp_fine(delay);
         end else begin
            pre_d[i] = pre_q[i];
         end
      end
      case (state_q)
         S_IDLE: begin
            if (set && !busy_q) begin
               tgt_d   = pre_q;
               mode_d  = step_mode;
               state_d = S_PIPE;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_PIPE: begin
            nxt_d   = nxt_s;
            state_d = S_APPLY;
         end
         S_APPLY: begin
            if (mode_q && !all_eq_s) begin
               wait_d  = SETTLE_LAST;
               state_d = S_WAIT;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WAIT: begin
            if (wait_q == 8'd0) begin
               state_d = S_PIPE;
            end else begin
               wait_d = wait_q - 8'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      // lane strobes are registered, so they trail the sequencer state by one cycle
      ldpipeen_d = (state_q == S_PIPE);
      ld_d       = (state_q == S_APPLY);
      busy_d     = (state_d != S_IDLE) | ld_d;
   end

   // control state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         mode_q     <= 1'b0;
         wait_q     <= 8'd0;
         ldpipeen_q <= 1'b0;
         ld_q       <= 1'b0;
         busy_q     <= 1'b0;
         fine_err_q <= 1'b0;
         for (int i = 0; i < NUM_CHN; i++) begin
            pre_q[i] <= RST_DLY;
            tgt_q[i] <= RST_DLY;
            nxt_q[i] <= RST_DLY;
         end
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         wait_q     <= wait_d;
         ldpipeen_q <= ldpipeen_d;
         ld_q       <= ld_d;
         busy_q     <= busy_d;
         fine_err_q <= fine_err_d;
         pre_q      <= pre_d;
         tgt_q      <= tgt_d;
         nxt_q      <= nxt_d;
      end
   end

   for (genvar g = 0; g < NUM_CHN; g++) begin : g_lane
      idelay_fine_lane #(
         .INIT (RST_DLY)
      ) u_lane (
         .clk        (clk),
         .regrst     (rst),
         .ldpipeen   (ldpipeen_q),
         .ld         (ld_q),
         .cntvaluein (nxt_q[g][7:3]),
         .ifdly      (nxt_q[g][2:0]),
         .idatain    (data_in[g]),
         .dataout    (data_out[g]),
         .dlyout     (cur_s[g])
      );
   end

   assign busy     = busy_q;
   assign fine_err = fine_err_q;
endmodule
